line_window_buffer: RTL and testbench

Multi-channel, parametrised vertical line buffer feeding the neighbourhood filters in the video pipeline. It stores the previous BUF_DEPTH-1 lines of every channel in synchronous-read RAMs. Each accepted pixel produces one registered vertical column of BUF_DEPTH pixels, with vertical border handling at the top of the frame. It also tracks frame and line state, and flags over-long lines.

---
 rtl/line_buf_pkg.sv | 20 ++
 rtl/line_ram.sv | 30 +++
 rtl/line_window_buffer.sv | 162 ++++++++++++++++
 tb/tb_line_window_buffer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_buf_pkg.sv
// rtl/line_buf_pkg.sv - shared types and width helpers for the line window buffer
package line_buf_pkg;

  // How rows above the top of the frame are filled
  typedef enum logic {
    BORDER_ZERO = 1'b0,
    BORDER_REPL = 1'b1
  } border_mode_e;

  // Width of one packed pixel (all channels)
  function automatic int pix_width(input int channels, input int colordepth);
    return channels * colordepth;
  endfunction

  // LSB position of row k inside the packed output column
  function automatic int row_lsb(input int row, input int pix_w);
    return row * pix_w;
  endfunction

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - simple dual-port line memory with synchronous read
module line_ram #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 1600,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents are never cleared, the top masks them until lines are filled
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port returns the pre-write value on a same-address collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_window_buffer.sv
// rtl/line_window_buffer.sv - multi-channel vertical line buffer with top-border handling
module line_window_buffer
  import line_buf_pkg::*;
#(
  parameter int  COLORDEPTH  = 8,
  parameter int  CHANNELS    = 3,
  parameter int  SCREENWIDTH = 1600,
  parameter int  BUF_DEPTH   = 3,
  localparam int ADDR_W      = $clog2(SCREENWIDTH),
  localparam int PIX_W       = pix_width(CHANNELS, COLORDEPTH),
  localparam int LF_W        = $clog2(BUF_DEPTH)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    frame_start,
  input  logic                                    line_end,
  input  logic                                    dv_i,
  input  logic [CHANNELS*COLORDEPTH-1:0]          data_i,
  input  logic                                    border_mode,
  output logic                                    dv_o,
  output logic                                    col_full_o,
  output logic [BUF_DEPTH*CHANNELS*COLORDEPTH-1:0] buff_o,
  output logic [LF_W-1:0]                         lines_filled_o,
  output logic                                    overflow_o
);

  // The column counter must be able to sit at SCREENWIDTH itself, which needs an
  // extra bit whenever SCREENWIDTH is a power of two.
  localparam int               CNT_W  = $clog2(SCREENWIDTH + 1);
  localparam logic [CNT_W-1:0] SW_CNT = CNT_W'(SCREENWIDTH);
  localparam logic [LF_W-1:0]  LF_MAX = LF_W'(BUF_DEPTH - 1);
  localparam int               NRAM   = BUF_DEPTH - 1;

  logic [CNT_W-1:0]  addr;
  logic [CNT_W-1:0]  addr_eff;
  logic [LF_W-1:0]   lines_filled;
  logic [LF_W-1:0]   lf_use;
  logic              overflow;
  logic              in_range;
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr;

  logic              dv_r;
  logic              wr_ok_r;
  logic              byp_r;
  border_mode_e      bm_r;
  logic [PIX_W-1:0]  data_r;
  logic [ADDR_W-1:0] addr_r;
  logic [LF_W-1:0]   lf_r;

  logic [PIX_W-1:0]  q_ram [1:NRAM];
  logic [PIX_W-1:0]  q_eff [1:NRAM];
  logic [PIX_W-1:0]  wdata [1:NRAM];
  logic [PIX_W-1:0]  byp_d [1:NRAM];
  logic [PIX_W-1:0]  rows  [BUF_DEPTH];
  logic [PIX_W-1:0]  col   [BUF_DEPTH];

  // A frame_start arriving with a pixel restarts the column and line count for that pixel
  always_comb begin
    addr_eff = frame_start ? '0 : addr;
    lf_use   = frame_start ? '0 : lines_filled;
    in_range = (addr_eff < SW_CNT);
    rd_en    = dv_i && in_range;
    rd_addr  = addr_eff[ADDR_W-1:0];
    wr_en    = dv_r && wr_ok_r;
  end

  // Column address, completed-line count and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr         <= '0;
      lines_filled <= '0;
      overflow     <= 1'b0;
    end else begin
      if (line_end)   addr <= '0;
      else if (rd_en) addr <= addr_eff + CNT_W'(1);
      else            addr <= addr_eff;

      if (frame_start)
        lines_filled <= '0;
      else if (line_end && (lines_filled != LF_MAX))
        lines_filled <= lines_filled + LF_W'(1);

      overflow <= (overflow && !frame_start) || (dv_i && !in_range);
    end
  end

  // Pixel stage: capture the pixel and its context; an overflowing pixel sees no real rows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_r    <= 1'b0;
      wr_ok_r <= 1'b0;
      byp_r   <= 1'b0;
      bm_r    <= BORDER_ZERO;
      data_r  <= '0;
      addr_r  <= '0;
      lf_r    <= '0;
      for (int k = 1; k <= NRAM; k++) byp_d[k] <= '0;
    end else begin
      dv_r <= dv_i;
      if (dv_i) begin
        data_r  <= data_i;
        addr_r  <= rd_addr;
        wr_ok_r <= in_range;
        lf_r    <= in_range ? lf_use : '0;
        bm_r    <= border_mode_e'(border_mode);
      end
      // The RAM returns stale data when it is read at the address being written
      // in the same cycle, so remember the written data to substitute next cycle.
      byp_r <= rd_en && wr_en && (rd_addr == addr_r);
      for (int k = 1; k <= NRAM; k++) byp_d[k] <= wdata[k];
    end
  end

  // Cascaded line RAMs: RAM 1 takes the new pixel, RAM k takes what RAM k-1 held
  for (genvar k = 1; k <= NRAM; k++) begin : g_ram
    if (k == 1) begin : g_first
      assign wdata[k] = data_r;
    end else begin : g_casc
      assign wdata[k] = q_eff[k-1];
    end

    assign q_eff[k] = byp_r ? byp_d[k] : q_ram[k];

    line_ram #(
      .WIDTH (PIX_W),
      .DEPTH (SCREENWIDTH),
      .AW    (ADDR_W)
    ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_en),
      .waddr (addr_r),
      .wdata (wdata[k]),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (q_ram[k])
    );
  end

  // Rows above the filled region are zeroed or copy the oldest real row
  always_comb begin
    rows[0] = data_r;
    for (int k = 1; k < BUF_DEPTH; k++) rows[k] = q_eff[k];
    for (int k = 0; k < BUF_DEPTH; k++) begin
      if (LF_W'(k) <= lf_r)         col[k] = rows[k];
      else if (bm_r == BORDER_REPL) col[k] = rows[lf_r];
      else                          col[k] = '0;
    end
  end

  for (genvar k = 0; k < BUF_DEPTH; k++) begin : g_pack
    assign buff_o[row_lsb(k, PIX_W) +: PIX_W] = col[k];
  end

  assign dv_o           = dv_r;
  assign col_full_o     = dv_r && (lf_r == LF_MAX);
  assign lines_filled_o = lines_filled;
  assign overflow_o     = overflow;

endmodule

// File: tb/tb_line_window_buffer.sv
// tb/tb_line_window_buffer.sv - self-checking bench for line_window_buffer
module tb_line_window_buffer;

  localparam int SW = 8;
  localparam int BD = 3;
  localparam int PW = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             frame_start = 1'b0;
  logic             line_end = 1'b0;
  logic             dv_i = 1'b0;
  logic [PW-1:0]    data_i = '0;
  logic             border_mode = 1'b0;
  logic             dv_o;
  logic             col_full_o;
  logic [BD*PW-1:0] buff_o;
  logic [1:0]       lines_filled_o;
  logic             overflow_o;

  int n_chk = 0;
  int n_fail = 0;

  line_window_buffer #(
    .COLORDEPTH  (8),
    .CHANNELS    (2),
    .SCREENWIDTH (SW),
    .BUF_DEPTH   (BD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .line_end       (line_end),
    .dv_i           (dv_i),
    .data_i         (data_i),
    .border_mode    (border_mode),
    .dv_o           (dv_o),
    .col_full_o     (col_full_o),
    .buff_o         (buff_o),
    .lines_filled_o (lines_filled_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] px(input logic [7:0] v);
    return {~v, v};
  endfunction

  function automatic logic [BD*PW-1:0] row3(input logic [PW-1:0] r0, input logic [PW-1:0] r1,
                                            input logic [PW-1:0] r2);
    return {r2, r1, r0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: every column keeps its own history of written pixels,
  // row k of a column is the k-th most recent earlier pixel at that column.
  logic [PW-1:0]    h  [SW][BD-1];
  bit               hv [SW][BD-1];
  int               col_m, lf_m, mc, lfu, lfe;
  bit               ovf_m, ovp;
  logic [PW-1:0]    r  [BD];
  bit               kn [BD];
  bit               e_dv, e_full, e_known;
  logic [BD*PW-1:0] e_buff;

  always @(posedge clk) begin
    if (rst) begin
      col_m = 0;
      lf_m = 0;
      ovf_m = 0;
      for (int c = 0; c < SW; c++)
        for (int j = 0; j < BD-1; j++) hv[c][j] = 0;
      e_dv = 0;
      e_full = 0;
      e_known = 1;
      e_buff = '0;
    end else begin
      mc = frame_start ? 0 : col_m;
      lfu = frame_start ? 0 : lf_m;
      ovp = dv_i && (mc == SW);
      e_dv = dv_i;
      e_full = 0;
      e_known = 1;
      if (dv_i) begin
        lfe = ovp ? 0 : lfu;
        for (int k = 0; k < BD; k++) begin
          if (k == 0) begin
            r[k] = data_i;
            kn[k] = 1;
          end else if (k <= lfe) begin
            r[k] = h[mc][k-1];
            kn[k] = hv[mc][k-1];
          end else begin
            r[k] = border_mode ? r[lfe] : '0;
            kn[k] = border_mode ? kn[lfe] : 1'b1;
          end
          e_buff[k*PW +: PW] = r[k];
          e_known = e_known && kn[k];
        end
        e_full = (lfe == BD-1);
        if (!ovp) begin
          for (int j = BD-2; j > 0; j--) begin
            h[mc][j] = h[mc][j-1];
            hv[mc][j] = hv[mc][j-1];
          end
          h[mc][0] = data_i;
          hv[mc][0] = 1;
        end
      end
      ovf_m = (frame_start ? 1'b0 : ovf_m) | ovp;
      lf_m = frame_start ? 0 : ((line_end && lf_m < BD-1) ? lf_m + 1 : lf_m);
      col_m = line_end ? 0 : ((dv_i && !ovp) ? mc + 1 : mc);
    end
    #1;
    chk("m_dv_o", dv_o, e_dv);
    chk("m_col_full_o", col_full_o, e_full);
    chk("m_lines_filled_o", lines_filled_o, lf_m);
    chk("m_overflow_o", overflow_o, ovf_m);
    if (e_dv) begin
      if (!e_known) begin
        n_chk++;
        n_fail++;
        $display("FAIL m_buff_o: model has no history for a real row at %0t", $time);
      end else begin
        chk("m_buff_o", buff_o, e_buff);
      end
    end
  end

  task automatic cyc(input bit fs, input bit le, input bit dv, input logic [7:0] v, input bit bm);
    @(negedge clk);
    frame_start = fs;
    line_end = le;
    dv_i = dv;
    data_i = px(v);
    border_mode = bm;
  endtask

  task automatic settle;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_dv_o", dv_o, 0);
    chk("rst_col_full_o", col_full_o, 0);
    chk("rst_buff_o", buff_o, 0);
    chk("rst_lines_filled_o", lines_filled_o, 0);
    chk("rst_overflow_o", overflow_o, 0);
    rst = 0;

    // Four lines of eight pixels, value = line*16 + col
    for (int ln = 0; ln < 4; ln++) begin
      for (int c = 0; c < 8; c++) begin
        cyc(0, c == 7, 1, 8'(ln * 16 + c), ln == 1);
        if (ln == 0 && c == 5) begin
          settle;
          chk("zero_border_l0c5", buff_o, row3(px(8'h05), '0, '0));
          chk("zero_border_full", col_full_o, 0);
        end
        if (ln == 1 && c == 5) begin
          settle;
          chk("repl_border_l1c5", buff_o, row3(px(8'h15), px(8'h05), px(8'h05)));
          chk("repl_border_full", col_full_o, 0);
        end
        if (ln == 3 && c == 2) begin
          settle;
          chk("full_col_l3c2", buff_o, row3(px(8'h32), px(8'h22), px(8'h12)));
          chk("full_col_flag", col_full_o, 1);
        end
      end
    end
    cyc(0, 0, 0, 0, 0);
    settle;
    chk("lines_filled_sat", lines_filled_o, 2);

    // Over-long line: ten pixels into an eight-wide buffer
    cyc(1, 0, 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      cyc(0, c == 9, 1, 8'(8'h40 + c), 1);
      if (c == 7) begin
        settle;
        chk("ovf_not_early", overflow_o, 0);
      end
      if (c == 8) begin
        settle;
        chk("ovf_set", overflow_o, 1);
        chk("ovf_col_dv", dv_o, 1);
        chk("ovf_col_border", buff_o, row3(px(8'h48), px(8'h48), px(8'h48)));
        chk("ovf_col_full", col_full_o, 0);
      end
    end
    for (int c = 0; c < 8; c++) begin
      cyc(0, c == 7, 1, 8'(8'h50 + c), 0);
      if (c == 3) begin
        settle;
        chk("after_ovf_rows", buff_o, row3(px(8'h53), px(8'h43), '0));
        chk("ovf_held", overflow_o, 1);
      end
    end
    cyc(1, 0, 0, 0, 0);
    settle;
    chk("ovf_cleared_by_fs", overflow_o, 0);
    chk("lf_cleared_by_fs", lines_filled_o, 0);

    // One-pixel lines back to back exercise the read-during-write bypass
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 8'(i), 0);
    settle;
    chk("bypass_rows", buff_o, row3(px(8'h02), px(8'h01), px(8'h00)));
    chk("bypass_full", col_full_o, 1);

    // Reset in the middle of line 2 with a pixel in flight
    cyc(1, 0, 0, 0, 0);
    for (int c = 0; c < 8; c++) cyc(0, c == 7, 1, 8'(8'h60 + c), 1);
    for (int c = 0; c < 8; c++) cyc(0, c == 7, 1, 8'(8'h70 + c), 1);
    for (int c = 0; c < 5; c++) cyc(0, 0, 1, 8'(8'h80 + c), 1);
    #2;
    rst = 1;
    #1;
    chk("midrst_dv_o", dv_o, 0);
    chk("midrst_col_full_o", col_full_o, 0);
    chk("midrst_buff_o", buff_o, 0);
    chk("midrst_lines_filled_o", lines_filled_o, 0);
    chk("midrst_overflow_o", overflow_o, 0);
    @(posedge clk);
    #1;
    rst = 0;
    cyc(0, 0, 1, 8'h90, 1);
    settle;
    chk("post_rst_border", buff_o, row3(px(8'h90), px(8'h90), px(8'h90)));
    chk("post_rst_full", col_full_o, 0);
    for (int c = 1; c < 8; c++) cyc(0, c == 7, 1, 8'(8'h90 + c), 1);
    for (int c = 0; c < 8; c++) begin
      cyc(0, c == 7, 1, 8'(8'hA0 + c), 1);
      if (c == 2) begin
        settle;
        chk("post_rst_line1", buff_o, row3(px(8'hA2), px(8'h92), px(8'h92)));
      end
    end

    // frame_start together with a pixel in the middle of a line
    for (int c = 0; c < 4; c++) cyc(0, 0, 1, 8'(8'hB0 + c), 0);
    cyc(1, 0, 1, 8'hC0, 0);
    settle;
    chk("fs_dv_border", buff_o, row3(px(8'hC0), '0, '0));
    chk("fs_dv_lf", lines_filled_o, 0);
    chk("fs_dv_full", col_full_o, 0);
    for (int c = 1; c < 8; c++) cyc(0, c == 7, 1, 8'(8'hC0 + c), 0);
    cyc(0, 0, 1, 8'hD0, 0);
    settle;
    chk("fs_dv_at_addr0", buff_o, row3(px(8'hD0), px(8'hC0), '0));
    for (int c = 1; c < 8; c++) cyc(0, c == 7, 1, 8'(8'hD0 + c), 0);

    // frame_start wins over a coincident line_end
    cyc(1, 1, 0, 0, 0);
    settle;
    chk("fs_le_lf", lines_filled_o, 0);

    repeat (3) cyc(0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
